// File: rtl/trace_buffer_pkg.sv
// Shared types for the commit-trace capture block.
// Provides the stored entry layout, the capture mode and FSM state
// encodings, and a decoder that folds reserved mode values into
// stop-when-full behaviour.
package trace_buffer_pkg;

  localparam int unsigned TRACE_CYCLE_W = 32;

  typedef enum logic [1:0] {
    MODE_STOP_FULL = 2'd0,
    MODE_WRAP      = 2'd1,
    MODE_POST_ONLY = 2'd2
  } trace_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } trace_state_t;

  typedef struct packed {
    logic [TRACE_CYCLE_W-1:0] cycle;
    logic [31:0]              pc;
    logic [31:0]              instr;
    logic [4:0]               rd;
    logic [31:0]              data;
    logic                     we;
  } trace_entry_t;

  // Mode 3 is reserved and treated as stop-when-full.
  function automatic trace_mode_t decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_WRAP;
      2'd2:    return MODE_POST_ONLY;
      default: return MODE_STOP_FULL;
    endcase
  endfunction

endpackage

// File: rtl/trace_buffer_if.sv
// Retire-side capture bus plus the readout valid/ready stream.
//   retire_*  : WB-stage retirement record (core -> trace buffer)
//   rd_valid  : oldest entry available (trace buffer -> consumer)
//   rd_ready  : consumer accepts entry
//   rd_entry  : oldest unread entry
// master = core/consumer side, slave = trace buffer side.
interface trace_buffer_if;
  import trace_buffer_pkg::*;

  logic         retire_valid;
  logic [31:0]  retire_pc;
  logic [31:0]  retire_instr;
  logic [4:0]   retire_rd;
  logic [31:0]  retire_data;
  logic         retire_we;
  logic         rd_valid;
  logic         rd_ready;
  trace_entry_t rd_entry;

  modport master (
    output retire_valid, retire_pc, retire_instr, retire_rd, retire_data,
           retire_we, rd_ready,
    input  rd_valid, rd_entry
  );

  modport slave (
    input  retire_valid, retire_pc, retire_instr, retire_rd, retire_data,
           retire_we, rd_ready,
    output rd_valid, rd_entry
  );

endinterface

// File: rtl/trace_buffer_ring_mem.sv
// Trace storage: DEPTH x WIDTH flop array, one synchronous write port
// and one asynchronous read port. Storage is intentionally not reset.
//   clk   : clock
//   we    : write enable, waddr/wdata written on the rising edge
//   raddr : read address, rdata follows combinationally
module trace_ring_mem #(
  parameter  int unsigned DEPTH = 64,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/trace_buffer.sv
// Commit-trace capture: records one entry per retired instruction into a
// ring buffer under an arm/trigger/post-trigger FSM, then drains the
// captured entries over a valid/ready stream.
//   clk, rst       : clock, synchronous active-high reset
//   start / abort  : restart capture / freeze capture
//   mode           : capture mode, sampled on start
//   trig_*         : PC-match and external trigger sources
//   post_count     : entries captured after trigger, sampled on start
//   cycle_count    : cycle stamp stored with each entry
//   bus            : retire capture bus and readout stream
//   state, triggered, overflow, count, dropped : status
module trace_buffer
  import trace_buffer_pkg::*;
#(
  parameter  int unsigned DEPTH   = 64,
  parameter  int unsigned CYCLE_W = 32,
  localparam int unsigned PTR_W   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [1:0]          mode,
  input  logic                trig_pc_en,
  input  logic [31:0]         trig_pc,
  input  logic                trig_ext,
  input  logic [PTR_W:0]      post_count,
  input  logic [CYCLE_W-1:0]  cycle_count,
  trace_buffer_if.slave       bus,
  output trace_state_t        state,
  output logic                triggered,
  output logic                overflow,
  output logic [PTR_W:0]      count,
  output logic [15:0]         dropped
);

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_MAX1 = (PTR_W+1)'(DEPTH-1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(DEPTH-1);
  localparam logic [15:0]      DROP_ONE = 16'd1;

  trace_state_t     state_q, state_d;
  trace_mode_t      mode_q, mode_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] post_q, post_d;
  logic [PTR_W-1:0] remain_q, remain_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             triggered_q, triggered_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      dropped_q, dropped_d;

  logic             hit;
  logic             cap;
  logic             rd_fire;
  trace_entry_t     wr_entry;
  trace_entry_t     mem_rdata;

  assign bus.rd_valid = (state_q == DONE) && (count_q != '0);
  assign bus.rd_entry = bus.rd_valid ? mem_rdata : '0;
  assign rd_fire      = bus.rd_valid && bus.rd_ready;

  always_comb begin
    wr_entry       = '0;
    wr_entry.cycle = TRACE_CYCLE_W'(cycle_count);
    wr_entry.pc    = bus.retire_pc;
    wr_entry.instr = bus.retire_instr;
    wr_entry.rd    = bus.retire_rd;
    wr_entry.data  = bus.retire_data;
    wr_entry.we    = bus.retire_we;
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    post_d      = post_q;
    remain_d    = remain_q;
    count_d     = count_q;
    triggered_d = triggered_q;
    overflow_d  = overflow_q;
    dropped_d   = dropped_q;
    cap         = 1'b0;
    hit         = (bus.retire_valid && trig_pc_en && (bus.retire_pc == trig_pc))
                  || trig_ext;

    if (start) begin
      state_d     = ARMED;
      mode_d      = decode_mode(mode);
      post_d      = (post_count > CNT_MAX1) ? PTR_MAX : post_count[PTR_W-1:0];
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      triggered_d = 1'b0;
      overflow_d  = 1'b0;
      dropped_d   = '0;
    end else if (abort && (state_q == ARMED || state_q == POST)) begin
      state_d = DONE;
    end else begin
      case (state_q)
        ARMED: begin
          if (mode_q == MODE_STOP_FULL) begin
            cap = bus.retire_valid;
            if (cap && count_q == CNT_MAX1) state_d = DONE;
          end else if (hit) begin
            // The trigger-cycle retire is captured but not charged to remain.
            triggered_d = 1'b1;
            cap         = bus.retire_valid;
            if (post_q == '0) begin
              state_d = DONE;
            end else begin
              state_d  = POST;
              remain_d = post_q;
            end
          end else begin
            cap = bus.retire_valid && (mode_q == MODE_WRAP);
          end
        end
        POST: begin
          if (bus.retire_valid) begin
            cap      = 1'b1;
            remain_d = remain_q - PTR_ONE;
            if (remain_q == PTR_ONE ||
                (mode_q == MODE_POST_ONLY && count_q == CNT_MAX1)) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            count_d  = count_q - CNT_ONE;
          end
        end
        default: ;
      endcase
    end

    // A capture into a full ring overwrites the oldest entry.
    if (cap) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (count_q == CNT_FULL) begin
        rd_ptr_d   = rd_ptr_q + PTR_ONE;
        overflow_d = 1'b1;
        if (dropped_q != '1) dropped_d = dropped_q + DROP_ONE;
      end else begin
        count_d = count_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= MODE_STOP_FULL;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      post_q      <= '0;
      remain_q    <= '0;
      count_q     <= '0;
      triggered_q <= 1'b0;
      overflow_q  <= 1'b0;
      dropped_q   <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      post_q      <= post_d;
      remain_q    <= remain_d;
      count_q     <= count_d;
      triggered_q <= triggered_d;
      overflow_q  <= overflow_d;
      dropped_q   <= dropped_d;
    end
  end

  trace_ring_mem #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(trace_entry_t))
  ) u_mem (
    .clk   (clk),
    .we    (cap),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  assign state     = state_q;
  assign triggered = triggered_q;
  assign overflow  = overflow_q;
  assign count     = count_q;
  assign dropped   = dropped_q;

endmodule

// File: tb/tb_trace_buffer.sv
module tb_trace_buffer;
  import trace_buffer_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [1:0]       mode;
  logic             trig_pc_en;
  logic [31:0]      trig_pc;
  logic             trig_ext;
  logic [PTR_W:0]   post_count;
  logic [31:0]      cyc = '0;
  trace_state_t     st;
  logic             triggered;
  logic             overflow;
  logic [PTR_W:0]   count;
  logic [15:0]      dropped;

  trace_buffer_if bus ();

  trace_buffer #(
    .DEPTH   (DEPTH),
    .CYCLE_W (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .mode        (mode),
    .trig_pc_en  (trig_pc_en),
    .trig_pc     (trig_pc),
    .trig_ext    (trig_ext),
    .post_count  (post_count),
    .cycle_count (cyc),
    .bus         (bus),
    .state       (st),
    .triggered   (triggered),
    .overflow    (overflow),
    .count       (count),
    .dropped     (dropped)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  typedef struct {
    logic         rst, start, abort;
    logic [1:0]   mode;
    logic [2:0]   post;
    logic         tpe;
    logic [31:0]  tpc;
    logic         text;
    logic         rv;
    logic [31:0]  rpc;
    logic         rdy;
    trace_state_t e_state;
    logic [2:0]   e_count;
    logic         e_trig, e_ovf, e_rv;
    logic [15:0]  e_drop;
    logic [31:0]  e_pc;
  } vec_t;

  vec_t vecs[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic add(input int unsigned r, s, a, md, pn, tpe, tpc, tx, rv, rpc, rdy,
                     input trace_state_t es, input int unsigned ec, et, eo, ev, ed, epc);
    vec_t v;
    v.rst = 1'(r);  v.start = 1'(s); v.abort = 1'(a); v.mode = 2'(md);
    v.post = 3'(pn); v.tpe = 1'(tpe); v.tpc = tpc; v.text = 1'(tx);
    v.rv = 1'(rv); v.rpc = rpc; v.rdy = 1'(rdy);
    v.e_state = es; v.e_count = 3'(ec); v.e_trig = 1'(et); v.e_ovf = 1'(eo);
    v.e_rv = 1'(ev); v.e_drop = 16'(ed); v.e_pc = epc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_retire(input logic v, input logic [31:0] pc);
    bus.retire_valid = v;
    bus.retire_pc    = pc;
    bus.retire_instr = pc ^ 32'hA5A5_0000;
    bus.retire_data  = ~pc;
    bus.retire_rd    = pc[6:2];
    bus.retire_we    = pc[2];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_cyc;
    int unsigned waited;

    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0; trig_pc_en = 1'b0;
    trig_pc = '0; trig_ext = 1'b0; post_count = '0; bus.rd_ready = 1'b0;
    drive_retire(1'b0, 32'h0);

    // rst st ab md pc tpe tpc    tx rv rpc    rdy  state  cnt t o v d  pc
    // Reset, then STOP_FULL fill and drain
    add(1,0,0,0,0,0,0,     0,0,0,     0, IDLE, 0,0,0,0,0,0);
    add(0,1,0,0,0,0,0,     0,0,0,     0, ARMED,0,0,0,0,0,0);
    add(0,0,0,0,0,0,0,     0,1,'h100, 0, ARMED,1,0,0,0,0,0);
    add(0,0,0,0,0,0,0,     0,1,'h104, 0, ARMED,2,0,0,0,0,0);
    add(0,0,0,0,0,0,0,     0,1,'h108, 0, ARMED,3,0,0,0,0,0);
    add(0,0,0,0,0,0,0,     0,1,'h10C, 0, DONE, 4,0,0,1,0,'h100);
    add(0,0,0,0,0,0,0,     0,1,'h110, 0, DONE, 4,0,0,1,0,'h100);
    add(0,0,0,0,0,0,0,     0,1,'h114, 1, DONE, 3,0,0,1,0,'h104);
    add(0,0,0,0,0,0,0,     0,0,0,     1, DONE, 2,0,0,1,0,'h108);
    add(0,0,0,0,0,0,0,     0,0,0,     1, DONE, 1,0,0,1,0,'h10C);
    add(0,0,0,0,0,0,0,     0,0,0,     1, DONE, 0,0,0,0,0,0);
    // WRAP with PC trigger at 0x118, post_count=2
    add(0,1,0,1,2,1,'h118, 0,0,0,     0, ARMED,0,0,0,0,0,0);
    add(0,0,0,1,2,1,'h118, 0,1,'h100, 0, ARMED,1,0,0,0,0,0);
    add(0,0,0,1,2,1,'h118, 0,1,'h104, 0, ARMED,2,0,0,0,0,0);
    add(0,0,0,1,2,1,'h118, 0,1,'h108, 0, ARMED,3,0,0,0,0,0);
    add(0,0,0,1,2,1,'h118, 0,1,'h10C, 0, ARMED,4,0,0,0,0,0);
    add(0,0,0,1,2,1,'h118, 0,1,'h110, 0, ARMED,4,0,1,0,1,0);
    add(0,0,0,1,2,1,'h118, 0,1,'h114, 0, ARMED,4,0,1,0,2,0);
    add(0,0,0,1,2,1,'h118, 0,1,'h118, 0, POST, 4,1,1,0,3,0);
    add(0,0,0,1,2,1,'h118, 0,1,'h11C, 0, POST, 4,1,1,0,4,0);
    add(0,0,0,1,2,1,'h118, 0,1,'h120, 0, DONE, 4,1,1,1,5,'h114);
    add(0,0,0,1,2,1,'h118, 0,0,0,     1, DONE, 3,1,1,1,5,'h118);
    add(0,0,0,1,2,1,'h118, 0,0,0,     1, DONE, 2,1,1,1,5,'h11C);
    add(0,0,0,1,2,1,'h118, 0,0,0,     1, DONE, 1,1,1,1,5,'h120);
    add(0,0,0,1,2,1,'h118, 0,0,0,     1, DONE, 0,1,1,0,5,0);
    // POST_ONLY, external trigger with no retire, then backpressured drain
    add(0,1,0,2,3,0,0,     0,0,0,     0, ARMED,0,0,0,0,0,0);
    add(0,0,0,2,3,0,0,     0,1,'h200, 0, ARMED,0,0,0,0,0,0);
    add(0,0,0,2,3,0,0,     1,0,0,     0, POST, 0,1,0,0,0,0);
    add(0,0,0,2,3,0,0,     0,1,'h204, 0, POST, 1,1,0,0,0,0);
    add(0,0,0,2,3,0,0,     0,1,'h208, 0, POST, 2,1,0,0,0,0);
    add(0,0,0,2,3,0,0,     0,1,'h20C, 0, DONE, 3,1,0,1,0,'h204);
    add(0,0,0,2,3,0,0,     0,1,'h210, 0, DONE, 3,1,0,1,0,'h204);
    add(0,0,0,2,3,0,0,     1,0,0,     0, DONE, 3,1,0,1,0,'h204);
    add(0,0,0,2,3,0,0,     0,0,0,     1, DONE, 2,1,0,1,0,'h208);
    add(0,0,0,2,3,0,0,     0,0,0,     0, DONE, 2,1,0,1,0,'h208);
    add(0,0,0,2,3,0,0,     0,0,0,     1, DONE, 1,1,0,1,0,'h20C);
    add(0,0,0,2,3,0,0,     0,0,0,     1, DONE, 0,1,0,0,0,0);
    // start+retire, abort+trigger+retire in POST, restart from DONE
    add(0,1,0,1,3,1,'h300, 0,1,'h300, 0, ARMED,0,0,0,0,0,0);
    add(0,0,0,1,3,1,'h300, 0,1,'h2F0, 0, ARMED,1,0,0,0,0,0);
    add(0,0,0,1,3,1,'h300, 0,1,'h300, 0, POST, 2,1,0,0,0,0);
    add(0,0,0,1,3,1,'h300, 0,1,'h304, 0, POST, 3,1,0,0,0,0);
    add(0,0,1,1,3,1,'h300, 1,1,'h308, 0, DONE, 3,1,0,1,0,'h2F0);
    add(0,1,0,1,3,1,'h300, 0,0,0,     0, ARMED,0,0,0,0,0,0);
    // Reset mid-POST, then abort/retire/trigger in IDLE
    add(0,0,0,1,3,1,'h300, 0,1,'h300, 0, POST, 1,1,0,0,0,0);
    add(0,0,0,1,3,1,'h300, 0,1,'h304, 0, POST, 2,1,0,0,0,0);
    add(0,0,0,1,3,1,'h300, 0,1,'h308, 0, POST, 3,1,0,0,0,0);
    add(1,0,0,1,3,1,'h300, 0,0,0,     0, IDLE, 0,0,0,0,0,0);
    add(0,0,1,1,3,1,'h300, 0,0,0,     0, IDLE, 0,0,0,0,0,0);
    add(0,0,0,1,3,1,'h300, 1,1,'h300, 0, IDLE, 0,0,0,0,0,0);
    // post_count=0 goes straight to DONE
    add(0,1,0,1,0,1,'h400, 0,0,0,     0, ARMED,0,0,0,0,0,0);
    add(0,0,0,1,0,1,'h400, 0,1,'h400, 0, DONE, 1,1,0,1,0,'h400);
    // post_count=7 clamps to DEPTH-1
    add(0,1,0,1,7,1,'h500, 0,0,0,     0, ARMED,0,0,0,0,0,0);
    add(0,0,0,1,7,1,'h500, 0,1,'h500, 0, POST, 1,1,0,0,0,0);
    add(0,0,0,1,7,1,'h500, 0,1,'h504, 0, POST, 2,1,0,0,0,0);
    add(0,0,0,1,7,1,'h500, 0,1,'h508, 0, POST, 3,1,0,0,0,0);
    add(0,0,0,1,7,1,'h500, 0,1,'h50C, 0, DONE, 4,1,0,1,0,'h500);
    // reserved mode 3 ignores triggers like STOP_FULL
    add(0,1,0,3,0,1,'h700, 0,0,0,     0, ARMED,0,0,0,0,0,0);
    add(0,0,0,3,0,1,'h700, 0,1,'h700, 0, ARMED,1,0,0,0,0,0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; start = vecs[i].start; abort = vecs[i].abort;
      mode = vecs[i].mode; post_count = vecs[i].post; trig_pc_en = vecs[i].tpe;
      trig_pc = vecs[i].tpc; trig_ext = vecs[i].text; bus.rd_ready = vecs[i].rdy;
      drive_retire(vecs[i].rv, vecs[i].rpc);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.state", i), 32'(st), 32'(vecs[i].e_state));
      chk($sformatf("v%0d.count", i), 32'(count), 32'(vecs[i].e_count));
      chk($sformatf("v%0d.triggered", i), 32'(triggered), 32'(vecs[i].e_trig));
      chk($sformatf("v%0d.overflow", i), 32'(overflow), 32'(vecs[i].e_ovf));
      chk($sformatf("v%0d.rd_valid", i), 32'(bus.rd_valid), 32'(vecs[i].e_rv));
      chk($sformatf("v%0d.dropped", i), 32'(dropped), 32'(vecs[i].e_drop));
      chk($sformatf("v%0d.rd_pc", i), bus.rd_entry.pc, vecs[i].e_pc);
    end

    // Full entry contents including the cycle stamp.
    @(negedge clk);
    rst = 1'b0; start = 1'b1; abort = 1'b0; mode = 2'd0; post_count = '0;
    trig_pc_en = 1'b0; trig_ext = 1'b0; bus.rd_ready = 1'b0;
    drive_retire(1'b0, 32'h0);
    @(negedge clk);
    start = 1'b0;
    drive_retire(1'b1, 32'h80C);
    exp_cyc = cyc;
    @(negedge clk);
    drive_retire(1'b0, 32'h0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    waited = 0;
    while (!bus.rd_valid && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    chk("hs.rd_valid_wait", 32'(bus.rd_valid), 32'd1);
    chk("hs.count", 32'(count), 32'd1);
    chk("hs.cycle", bus.rd_entry.cycle, exp_cyc);
    chk("hs.pc", bus.rd_entry.pc, 32'h0000_080C);
    chk("hs.instr", bus.rd_entry.instr, 32'hA5A5_080C);
    chk("hs.data", bus.rd_entry.data, 32'hFFFF_F7F3);
    chk("hs.rd", 32'(bus.rd_entry.rd), 32'd3);
    chk("hs.we", 32'(bus.rd_entry.we), 32'd1);
    bus.rd_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hs.drained_valid", 32'(bus.rd_valid), 32'd0);
    chk("hs.drained_count", 32'(count), 32'd0);
    chk("hs.drained_entry", bus.rd_entry.pc, 32'd0);
    bus.rd_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/trace_buffer.md
Name: trace_buffer

Overview:
Synthesizable on-chip commit-trace capture for the 5-stage core. It records one entry per retired instruction from the WB stage into a parametrised ring buffer. Capture is controlled by an arm/trigger/post-trigger state machine, and the buffer drains over a valid/ready stream for off-chip or debug-bus readout. It provides in silicon the per-cycle visibility that file-based simulation tracing gives.

Parameters:
DEPTH, 64, entry count; power of 2, at least 4
CYCLE_W, 32, width of the cycle stamp stored per entry
PTR_W, $clog2(DEPTH), derived pointer width; not overridden

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
start  in  1  pulse: clear buffer, enter ARMED
abort  in  1  pulse: freeze capture, enter DONE
mode  in  2  trace_mode_t; sampled only on start
trig_pc_en  in  1  enables PC-match trigger
trig_pc  in  32  trigger PC
trig_ext  in  1  external trigger pulse
post_count  in  PTR_W+1  entries to capture after trigger; sampled on start, clamped to DEPTH-1
cycle_count  in  CYCLE_W  free-running cycle stamp
retire_valid  in  1  WB stage holds a valid instruction this cycle
retire_pc  in  32  WB PC
retire_instr  in  32  WB instruction
retire_rd  in  5  destination register
retire_data  in  32  write-back data
retire_we  in  1  register write enable
rd_valid  out  1  entry available (DONE state and count!=0)
rd_ready  in  1  consumer accepts entry
rd_entry  out  $bits(trace_entry_t)  oldest unread entry
state  out  2  trace_state_t
triggered  out  1  sticky; trigger seen since start
overflow  out  1  sticky; an entry was overwritten or dropped
count  out  PTR_W+1  entries currently held
dropped  out  16  dropped/overwritten entries, saturating at 16'hFFFF

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE; count, pointers, triggered, overflow, dropped = 0; rd_valid=0; rd_entry=0. Memory contents are don't-care.
- Capture event: retire_valid=1 while state is ARMED or POST, subject to mode gating below. It writes {cycle_count, pc, instr, rd, data, we} at wr_ptr in the same edge. Zero latency; the entry is visible in count on the next cycle.
- Trigger hit: retire_valid && trig_pc_en && retire_pc==trig_pc, OR trig_ext (independent of retire_valid).
- States:
  - IDLE: no capture.
  - start -> ARMED: wr_ptr, rd_ptr and count cleared; triggered and overflow cleared; dropped cleared.
  - ARMED: on trigger hit -> POST, remaining=post_count, triggered=1. The trigger-cycle retire is captured and is not counted in remaining. If post_count==0 -> DONE directly.
  - POST: each capture decrements remaining. When remaining reaches 0 on a capture -> DONE.
  - DONE: capture frozen, readout enabled. start -> ARMED.
- Modes:
  - MODE_STOP_FULL (0): ARMED captures until count==DEPTH, then -> DONE. Triggers are ignored.
  - MODE_WRAP (1): circular buffer. A write at count==DEPTH overwrites the oldest entry: rd_ptr++, overflow=1, dropped++. Trigger/POST apply as above.
  - MODE_POST_ONLY (2): ARMED captures nothing. Entries are captured from the trigger cycle onward. In POST, reaching count==DEPTH -> DONE even if remaining>0.
  - Mode 3 is reserved and behaves as MODE_STOP_FULL.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH.
- Readout handshake:
  - rd_entry = mem[rd_ptr], combinational from the flop array.
  - A transfer occurs when rd_valid && rd_ready; then rd_ptr++ and count--.
  - rd_entry and rd_valid hold stable while rd_valid && !rd_ready.
  - Draining does not clear triggered or overflow.
- Simultaneous events, priority rst > start > abort > trigger > capture:
  - start in the same cycle as retire_valid: that retire is not captured.
  - abort in ARMED or POST -> DONE; a retire in that cycle is not captured.
  - start during ARMED, POST or DONE restarts cleanly and discards unread entries.
  - start/abort in IDLE: abort is ignored.
- trig_ext pulses in POST or DONE are ignored. Only the first trigger after start counts.
- dropped is 16 bits, saturating; it does not wrap.

Decomposition:
- riscvibe_pkg additions:
  - trace_entry_t packed struct (cycle[CYCLE_W default 32], pc, instr, rd, data, we)
  - trace_mode_t enum (MODE_STOP_FULL, MODE_WRAP, MODE_POST_ONLY)
  - trace_state_t enum (IDLE, ARMED, POST, DONE)
- Sub-module trace_ring_mem: DEPTH x $bits(trace_entry_t) flop array, one synchronous write port, one asynchronous read port, no reset on storage.
- The FSM, pointers, counters and handshake stay in trace_buffer.

Test Plan:
- STOP_FULL, DEPTH=4, start, then 6 retires with pc=0x100..0x114 -> state=DONE after the 4th. Drain with rd_ready=1 yields pc 0x100,0x104,0x108,0x10C in order; overflow=0.
- WRAP, DEPTH=4, post_count=2, trig_pc=0x118, 10 retires pc=0x100+4k -> trigger at k=6. DONE after pc 0x120. Buffer holds 0x114,0x118,0x11C,0x120; overflow=1; dropped=5.
- POST_ONLY, trig_ext pulse at cycle 20 with no retire, post_count=3, then 5 retires -> DONE with count=3 (first three retires); triggered=1.
- Backpressure: DONE with count=3, rd_ready toggling 0,0,1,0,1,1 -> rd_entry stable during stalls; exactly 3 transfers; rd_valid=0 afterwards; count=0.
- Simultaneous start+retire, and abort+trigger in POST -> the retire is not captured. Abort wins, giving DONE with count unchanged, and triggered remains as before the cycle.
- Reset asserted mid-POST with count=3 -> next cycle state=IDLE, count=0, rd_valid=0, triggered=0, dropped=0.
